ahb_lite_master: RTL
====================

Name: ahb_lite_master

Overview:
- Single-initiator AHB-Lite master bridging a simple valid/ready load-store request port onto the AHB bus.
- Sits between the core's memory stage and the slave decoder/mux that drives GPIO and memory slaves.
- Issues SINGLE NONSEQ transfers with full address/data-phase pipelining, honours `hready` wait states, and reports `hresp` errors back per request.
- Replays an address phase that is cancelled by an error.

Parameters:
- ADDR_WIDTH, 32, width of `haddr` / `req_addr`.
- DATA_WIDTH, 32, width of `hwdata` / `hrdata` / `req_wdata` / `rsp_rdata`; must be a power of two ≥ 8.
- HPROT_VAL, 4'b0011, constant driven on `hprot` (non-cacheable, non-bufferable, privileged data).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with `req_valid`.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  3  AHB HSIZE encoding, must be ≤ log2(DATA_WIDTH/8).
- req_wdata  in  DATA_WIDTH  write data, byte-lane aligned by the requester.
- rsp_valid  out  1  one-cycle pulse, one per accepted request, in order.
- rsp_rdata  out  DATA_WIDTH  raw `hrdata` lane for reads, 0 for writes.
- rsp_error  out  1  transfer ended with ERROR.
- haddr  out  ADDR_WIDTH  AHB address.
- hwrite  out  1  AHB direction.
- htrans  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- hsize  out  3  AHB size.
- hburst  out  3  constant SINGLE 3'b000.
- hprot  out  4  constant HPROT_VAL.
- hmastlock  out  1  constant 0.
- hwdata  out  DATA_WIDTH  write data during data phase.
- hrdata  in  DATA_WIDTH  read data.
- hready  in  1  transfer-complete / bus-ready.
- hresp  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Clocking and reset: one clock `HCLK`. `HRESETn` is asynchronous and active-low.
- Reset values: `htrans` = IDLE; `haddr`, `hwrite`, `hsize`, `hwdata`, `rsp_rdata` = 0; `rsp_valid` = 0; `rsp_error` = 0.
- Reset mid-operation: in-flight transfers are dropped and no response is emitted for them. `req_ready` is 0 while `HRESETn` is low.
- Pipeline registers:
  - Address-phase register AP: valid, write, addr, size, wdata.
  - Data-phase register DP: valid, write, wdata.
- All bus outputs are registered.
- Acceptance: `req_ready` = ~AP.valid | (`hready` & ~`hresp`). An accepted request loads AP and appears on the bus the next cycle (1-cycle request-to-address latency).
- Bus drive:
  - `htrans` = NONSEQ when AP.valid & ~AP.cancel, else IDLE.
  - `haddr`/`hwrite`/`hsize` come from AP and are held stable while `hready` = 0.
- Phase advance: on `hready` = 1, AP moves to DP and AP is refilled or cleared.
- Write data: `hwdata` is driven from DP.wdata throughout the data phase and held stable during wait states.
- Completion: in a cycle with DP.valid & `hready`:
  - `rsp_valid` pulses next cycle.
  - `rsp_error` = `hresp`.
  - `rsp_rdata` = `hrdata` if ~DP.write, else 0.
  - Read-to-response latency is 1 cycle after the final data-phase cycle.
- Error, two-cycle AHB response:
  - First error cycle (DP.valid & `hresp` & ~`hready`): if AP.valid, set AP.cancel so `htrans` = IDLE on the second cycle.
  - The errored transfer completes with `rsp_error` = 1.
  - The cancelled AP is re-issued as NONSEQ the following cycle, unmodified, then proceeds normally.
- Unexpected signalling: `hresp` = 1 with no DP.valid is ignored.
- Throughput: back-to-back requests with `hready` = 1 sustain 1 transfer per cycle.
- Simultaneous events: acceptance, DP completion and AP→DP advance may all occur in the same cycle.
- Ordering: responses are strictly in request order; at most one outstanding address phase and one data phase.
- Bus size: the bus is never locked and bursts are never issued.

Optional Feature:
- Macro: AHB_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A request whose `req_addr` is not aligned to 2^`req_size` bytes, or whose `req_size` > log2(DATA_WIDTH/8), is accepted but never issued on the bus.
  - It produces `rsp_valid` with `rsp_error` = 1 and `rsp_rdata` = 0, in order behind any outstanding transfers.
- Not defined: no check is made and the request is issued unmodified; the slave decides.

Test Plan:
- Single read, `req_addr` = 0x0000_0000, size 3'b010; slave `hready` = 1, `hrdata` = 0x0000_A5A5 → NONSEQ on cycle 1; `rsp_valid` with `rsp_rdata` = 0x0000_A5A5, `rsp_error` = 0 two cycles after the address phase.
- Back-to-back writes to 0x4 (0x0000_00FF) then 0x8 (0x00FF_0000), `hready` held 1 → `htrans` NONSEQ on consecutive cycles; `hwdata` = 0x0000_00FF then 0x00FF_0000 one cycle behind `haddr`; two OKAY responses.
- Read 0x4 with `hready` = 0 for 3 data-phase cycles, second request pending → `haddr` = second address held stable, `req_ready` = 0 during the stall; response only after `hready` rises.
- Write to 0x0 answered ERROR (`hresp` = 1 with `hready` 0 then 1), next read to 0x8 pipelined → `htrans` = IDLE in the second error cycle; first response has `rsp_error` = 1; read 0x8 re-issued as NONSEQ and completes OKAY.
- `HRESETn` asserted low mid data-phase of a read → outputs go to reset values immediately with no `rsp_valid`; after release, a new request completes normally.
- With AHB_MASTER_ALIGN_CHECK_EN: word read at 0x2 → no NONSEQ issued, `rsp_error` = 1, `rsp_rdata` = 0.

Source files
------------

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-initiator AHB-Lite master.
// Turns a valid/ready load-store request port into SINGLE NONSEQ AHB transfers.
// Address and data phases are pipelined. hready wait states are honoured.
// hresp errors are reported back per request, and an address phase that the
// master cancels during a two-cycle ERROR response is replayed unmodified.
// Optional build macro AHB_MASTER_ALIGN_CHECK_EN: a request that is misaligned
// or oversized is answered locally with an error and never reaches the bus.
module ahb_lite_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [1:0]            htrans,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic                  hmastlock,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam int SIZE_MAX = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  // Address-phase register. Its fields drive the bus directly.
  logic                  ap_valid, ap_cancel, ap_bad, ap_write;
  logic [ADDR_WIDTH-1:0] ap_addr;
  logic [2:0]            ap_size;
  logic [DATA_WIDTH-1:0] ap_wdata;
  // Next-state values for the address phase.
  logic                  ap_valid_d, ap_cancel_d, ap_bad_d, ap_write_d;
  logic [ADDR_WIDTH-1:0] ap_addr_d;
  logic [2:0]            ap_size_d;
  logic [DATA_WIDTH-1:0] ap_wdata_d;
  htrans_e               htrans_q, htrans_d;

  // Data-phase register.
  logic                  dp_valid, dp_bad, dp_write;
  logic [DATA_WIDTH-1:0] dp_wdata;

  logic req_bad, accept, ap_take, err_live;

`ifdef AHB_MASTER_ALIGN_CHECK_EN
  logic [ADDR_WIDTH-1:0] size_mask;
  assign size_mask = (ADDR_WIDTH'(1) << req_size) - ADDR_WIDTH'(1);
  assign req_bad   = (req_size > 3'(SIZE_MAX)) || ((req_addr & size_mask) != '0);
`else
  assign req_bad   = 1'b0;
`endif

  // An error counts only while a real transfer is in its data phase.
  // A stray hresp with no such transfer is ignored.
  assign err_live  = hresp & dp_valid & ~dp_bad;
  // The address phase completes on hready, unless the master cancelled it.
  assign ap_take   = ap_valid & hready & ~ap_cancel;
  assign req_ready = HRESETn & (~ap_valid | (hready & ~err_live & ~ap_cancel));
  assign accept    = req_valid & req_ready;

  assign haddr     = ap_addr;
  assign hwrite    = ap_write;
  assign hsize     = ap_size;
  assign htrans    = htrans_q;
  assign hwdata    = dp_wdata;
  assign hburst    = 3'b000;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;

  // Compute the next address phase: drain, error-cancel, replay or refill.
  always_comb begin
    // NOTE: every output of this block gets a default first, so a path that
    // assigns nothing holds the state value and no latch is inferred.
    ap_valid_d  = ap_valid;
    ap_cancel_d = ap_cancel;
    ap_bad_d    = ap_bad;
    ap_write_d  = ap_write;
    ap_addr_d   = ap_addr;
    ap_size_d   = ap_size;
    ap_wdata_d  = ap_wdata;
    if (ap_take) begin
      ap_valid_d  = 1'b0;
      ap_bad_d    = 1'b0;
    end
    // The second error cycle ends with hready high. Once the cancel has been
    // shown as IDLE, the same address phase is replayed in the next cycle.
    if (ap_cancel && hready) ap_cancel_d = 1'b0;
    // In the first error cycle, withdraw the pending address phase.
    if (ap_valid && err_live && !hready) ap_cancel_d = 1'b1;
    if (accept) begin
      ap_valid_d  = 1'b1;
      ap_cancel_d = 1'b0;
      ap_bad_d    = req_bad;
      ap_write_d  = req_write;
      ap_addr_d   = req_addr;
      ap_size_d   = req_size;
      ap_wdata_d  = req_wdata;
    end
    htrans_d = (ap_valid_d && !ap_cancel_d && !ap_bad_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  // Address-phase register and registered htrans.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid  <= 1'b0;
      ap_cancel <= 1'b0;
      ap_bad    <= 1'b0;
      ap_write  <= 1'b0;
      ap_addr   <= '0;
      ap_size   <= '0;
      ap_wdata  <= '0;
      htrans_q  <= HTRANS_IDLE;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every
      // register in this design samples its pre-edge inputs regardless of
      // the order in which the blocks are evaluated.
      ap_valid  <= ap_valid_d;
      ap_cancel <= ap_cancel_d;
      ap_bad    <= ap_bad_d;
      ap_write  <= ap_write_d;
      ap_addr   <= ap_addr_d;
      ap_size   <= ap_size_d;
      ap_wdata  <= ap_wdata_d;
      htrans_q  <= htrans_d;
    end
  end

  // Data-phase register. It advances only on hready, so hwdata stays stable
  // through wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_bad   <= 1'b0;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (hready) begin
      dp_valid <= ap_take;
      dp_bad   <= ap_take & ap_bad;
      dp_write <= ap_write;
      if (ap_take) dp_wdata <= ap_wdata;
    end
  end

  // Response: a one-cycle pulse after the final data-phase cycle.
  // Locally rejected requests always report an error and return zero data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dp_valid & hready;
      if (dp_valid && hready) begin
        rsp_error <= hresp | dp_bad;
        rsp_rdata <= (dp_write || dp_bad) ? '0 : hrdata;
      end
    end
  end

endmodule
